// File: rtl/mem_stage_ctl.sv
// mem_stage_ctl -- MEM pipeline stage sequencer placed directly in front of
// data_mem_unit. Accepts one instruction from EX per handshake, runs scalar
// (fixed SC_LAT wait) or vector (start pulse, wait for mem_rdy) memory ops,
// holds EX with stall while busy and hands a one-cycle result to WB.
// Non-memory instructions pass through with one cycle of latency.
//
// Build option: define MEM_TIMEOUT_EN to abort a vector op that sees no
// mem_rdy within TIMEOUT_CYCLES VEC_WAIT cycles; the abort returns a
// non-writing result and sets the sticky mem_err flag. Without the macro
// VEC_WAIT waits indefinitely and mem_err is tied low.

module mem_stage_ctl #(
   parameter int SC_LAT = 2
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic        clk,
   input  logic        reset,
   // EX side
   input  logic        ex_valid,
   input  logic        ex_is_mem,
   input  logic [1:0]  ex_mem_op,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_data_esc,
   input  logic [63:0] ex_data_vec,
   input  logic [4:0]  ex_rd,
   input  logic        ex_wb_en,
   input  logic        ex_wb_vec,
   output logic        stall,
   // data_mem_unit side
   output logic        mem_start,
   output logic [1:0]  mem_op,
   output logic [31:0] base_addr,
   output logic [31:0] data_in_esc,
   output logic [63:0] data_in_vec,
   input  logic        mem_rdy,
   input  logic [31:0] data_out_esc,
   input  logic [63:0] data_out_vec,
   // WB side
   output logic        wb_valid,
   output logic        wb_en,
   output logic        wb_vec,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data_esc,
   output logic [63:0] wb_data_vec,
   output logic        mem_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SC_WAIT,
      S_VEC_START,
      S_VEC_WAIT
   } state_t;

   // Op encoding: bit 1 = load, bit 0 = scalar. LD_ESC doubles as the idle
   // value on mem_op because it carries no write enable into the memory.
   localparam logic [1:0] OP_IDLE = 2'b11;

   localparam int              SC_W    = (SC_LAT > 1) ? $clog2(SC_LAT) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SC_LAT - 1);

   state_t            r_state;
   logic [SC_W-1:0]   r_sc_cnt;

   // Fields of the accepted instruction needed again at completion
   logic [4:0]        r_lat_rd;
   logic              r_lat_wb_en;
   logic              r_lat_wb_vec;

   // Registered memory-side outputs
   logic              r_mem_start;
   logic [1:0]        r_mem_op;
   logic [31:0]       r_base_addr;
   logic [31:0]       r_data_in_esc;
   logic [63:0]       r_data_in_vec;

   // Registered WB-side outputs
   logic              r_wb_valid;
   logic              r_wb_en;
   logic              r_wb_vec;
   logic [4:0]        r_wb_rd;
   logic [31:0]       r_wb_data_esc;
   logic [63:0]       r_wb_data_vec;

   logic              w_is_load;
   logic              w_sc_done;
   logic              w_vec_done;
   logic              w_abort;
   logic              w_finish;

   // Completion conditions for the op currently in flight.
   always_comb begin
      // NOTE: every signal written here is assigned on every pass through the
      // block, so no path can leave one unassigned and infer a latch.
      w_is_load  = r_mem_op[1];
      w_sc_done  = (r_state == S_SC_WAIT) && (r_sc_cnt == SC_LAST);
      w_vec_done = (r_state == S_VEC_WAIT) && mem_rdy;
      w_finish   = w_sc_done || w_vec_done || w_abort;
   end

`ifdef MEM_TIMEOUT_EN
   localparam int              TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int              TO_W     = (TO_W_RAW > 8) ? TO_W_RAW : 8;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_mem_err;

   // The last permitted VEC_WAIT cycle ends without mem_rdy: give up.
   assign w_abort = (r_state == S_VEC_WAIT) && !mem_rdy && (r_to_cnt == TO_LAST);

   // Count VEC_WAIT cycles of the current op and keep the sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt  <= '0;
         r_mem_err <= 1'b0;
      end else begin
         if ((r_state == S_VEC_WAIT) && !w_finish) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end else begin
            r_to_cnt <= '0;
         end
         if (w_abort) begin
            r_mem_err <= 1'b1;
         end
      end
   end

   assign mem_err = r_mem_err;
`else
   assign w_abort = 1'b0;
   assign mem_err = 1'b0;
`endif

   // Accept from EX, sequence the op and register every stage output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_sc_cnt      <= '0;
         r_lat_rd      <= '0;
         r_lat_wb_en   <= 1'b0;
         r_lat_wb_vec  <= 1'b0;
         r_mem_start   <= 1'b0;
         r_mem_op      <= OP_IDLE;
         r_base_addr   <= '0;
         r_data_in_esc <= '0;
         r_data_in_vec <= '0;
         r_wb_valid    <= 1'b0;
         r_wb_en       <= 1'b0;
         r_wb_vec      <= 1'b0;
         r_wb_rd       <= '0;
         r_wb_data_esc <= '0;
         r_wb_data_vec <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; the pulse defaults below
         // are overridden later in the block where a pulse is due.
         r_wb_valid  <= 1'b0;
         r_mem_start <= 1'b0;

         if (w_finish) begin
            // Op done (or aborted): present the result and park the memory port.
            r_state       <= S_IDLE;
            r_wb_valid    <= 1'b1;
            r_wb_en       <= w_is_load && r_lat_wb_en && !w_abort;
            r_wb_vec      <= r_lat_wb_vec;
            r_wb_rd       <= r_lat_rd;
            r_wb_data_esc <= (w_sc_done && w_is_load) ? data_out_esc : '0;
            r_wb_data_vec <= (w_vec_done && w_is_load) ? data_out_vec : '0;
            r_mem_op      <= OP_IDLE;
            r_base_addr   <= '0;
            r_data_in_esc <= '0;
            r_data_in_vec <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (ex_valid) begin
                     r_lat_rd     <= ex_rd;
                     r_lat_wb_en  <= ex_wb_en;
                     r_lat_wb_vec <= ex_wb_vec;
                     if (!ex_is_mem) begin
                        // Pass-through: result is ready on the next cycle.
                        r_wb_valid    <= 1'b1;
                        r_wb_en       <= ex_wb_en;
                        r_wb_vec      <= ex_wb_vec;
                        r_wb_rd       <= ex_rd;
                        r_wb_data_esc <= ex_data_esc;
                        r_wb_data_vec <= ex_data_vec;
                     end else begin
                        r_mem_op      <= ex_mem_op;
                        r_base_addr   <= ex_addr;
                        r_data_in_esc <= ex_data_esc;
                        r_data_in_vec <= ex_data_vec;
                        if (ex_mem_op[0]) begin
                           r_state  <= S_SC_WAIT;
                           r_sc_cnt <= '0;
                        end else begin
                           r_state     <= S_VEC_START;
                           r_mem_start <= 1'b1;
                        end
                     end
                  end
               end
               S_SC_WAIT: begin
                  r_sc_cnt <= r_sc_cnt + 1'b1;
               end
               S_VEC_START: begin
                  // mem_rdy is not looked at while the launch pulse is out.
                  r_state <= S_VEC_WAIT;
               end
               S_VEC_WAIT: begin
                  // Hold until mem_rdy (or timeout) completes the op above.
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign stall       = (r_state != S_IDLE);
   assign mem_start   = r_mem_start;
   assign mem_op      = r_mem_op;
   assign base_addr   = r_base_addr;
   assign data_in_esc = r_data_in_esc;
   assign data_in_vec = r_data_in_vec;
   assign wb_valid    = r_wb_valid;
   assign wb_en       = r_wb_en;
   assign wb_vec      = r_wb_vec;
   assign wb_rd       = r_wb_rd;
   assign wb_data_esc = r_wb_data_esc;
   assign wb_data_vec = r_wb_data_vec;

endmodule

// File: tb/tb_mem_stage_ctl.sv
// tb_mem_stage_ctl -- bench for mem_stage_ctl. A cycle-level reference model
// derived from the stage's latency rules predicts every output each cycle;
// directed scenarios add hand-computed literal expectations, then a long
// randomized run exercises arbitrary instruction mixes and mem_rdy timing.
// Define MEM_TIMEOUT_EN for both files to cover the timeout build.

module tb_mem_stage_ctl;

   localparam int SC_LAT = 2;
`ifdef MEM_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 0;
`endif

   localparam logic [1:0] LD_VEC = 2'b10;
   localparam logic [1:0] LD_ESC = 2'b11;
   localparam logic [1:0] ST_VEC = 2'b00;
   localparam logic [1:0] ST_ESC = 2'b01;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ex_valid, ex_is_mem, ex_wb_en, ex_wb_vec;
   logic [1:0]  ex_mem_op;
   logic [31:0] ex_addr, ex_data_esc;
   logic [63:0] ex_data_vec;
   logic [4:0]  ex_rd;
   logic        stall, mem_start, mem_rdy;
   logic [1:0]  mem_op;
   logic [31:0] base_addr, data_in_esc, data_out_esc;
   logic [63:0] data_in_vec, data_out_vec;
   logic        wb_valid, wb_en, wb_vec, mem_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data_esc;
   logic [63:0] wb_data_vec;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   mem_stage_ctl #(
      .SC_LAT(SC_LAT)
`ifdef MEM_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_is_mem(ex_is_mem), .ex_mem_op(ex_mem_op),
      .ex_addr(ex_addr), .ex_data_esc(ex_data_esc), .ex_data_vec(ex_data_vec),
      .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_wb_vec(ex_wb_vec),
      .stall(stall), .mem_start(mem_start), .mem_op(mem_op),
      .base_addr(base_addr), .data_in_esc(data_in_esc), .data_in_vec(data_in_vec),
      .mem_rdy(mem_rdy), .data_out_esc(data_out_esc), .data_out_vec(data_out_vec),
      .wb_valid(wb_valid), .wb_en(wb_en), .wb_vec(wb_vec), .wb_rd(wb_rd),
      .wb_data_esc(wb_data_esc), .wb_data_vec(wb_data_vec), .mem_err(mem_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // busy/age/waits describe the in-flight op in terms of elapsed cycles:
   // age = clock edges since the accept edge, waits = VEC_WAIT cycles seen
   // without mem_rdy.
   typedef struct {
      bit          busy;
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] desc;
      logic [63:0] dvec;
      logic [4:0]  rd;
      bit          wben;
      bit          wbvec;
      int          age;
      int          waits;
      bit          wb_valid;
      bit          wb_en;
      bit          wb_vec;
      logic [4:0]  wb_rd;
      logic [31:0] wb_esc;
      logic [63:0] wb_dvec;
      bit          chk_esc;
      bit          chk_vec;
      bit          err;
   } model_t;

   model_t mdl;

   function automatic bit is_load(input logic [1:0] op);
      return (op == LD_VEC) || (op == LD_ESC);
   endfunction

   function automatic bit is_scalar(input logic [1:0] op);
      return (op == LD_ESC) || (op == ST_ESC);
   endfunction

   function automatic model_t model_reset();
      model_t z;
      z = '{default: '0};
      return z;
   endfunction

   function automatic model_t result(input model_t s, input bit en, input logic [31:0] d_esc,
                                     input logic [63:0] d_vec, input bit c_esc, input bit c_vec);
      model_t n = s;
      n.wb_valid = 1'b1;
      n.wb_en    = en;
      n.wb_vec   = s.wbvec;
      n.wb_rd    = s.rd;
      n.wb_esc   = d_esc;
      n.wb_dvec  = d_vec;
      n.chk_esc  = c_esc;
      n.chk_vec  = c_vec;
      return n;
   endfunction

   function automatic model_t step(input model_t s);
      model_t n = s;
      n.wb_valid = 1'b0;
      if (!s.busy) begin
         if (ex_valid) begin
            n.rd    = ex_rd;
            n.wbvec = ex_wb_vec;
            n.wben  = ex_wb_en;
            if (!ex_is_mem) begin
               n = result(n, ex_wb_en, ex_data_esc, ex_data_vec, 1'b1, 1'b1);
            end else begin
               n.busy  = 1'b1;
               n.op    = ex_mem_op;
               n.addr  = ex_addr;
               n.desc  = ex_data_esc;
               n.dvec  = ex_data_vec;
               n.age   = 0;
               n.waits = 0;
            end
         end
      end else begin
         n.age = s.age + 1;
         if (is_scalar(s.op)) begin
            if (n.age == SC_LAT) begin
               n.busy = 1'b0;
               n = result(n, is_load(s.op) && s.wben, data_out_esc, 64'd0, is_load(s.op), 1'b0);
            end
         end else if (n.age >= 2) begin
            if (mem_rdy) begin
               n.busy = 1'b0;
               n = result(n, is_load(s.op) && s.wben, 32'd0, data_out_vec, 1'b0, is_load(s.op));
            end else begin
               n.waits = s.waits + 1;
               if ((TO > 0) && (n.waits == TO)) begin
                  n.busy = 1'b0;
                  n.err  = 1'b1;
                  n = result(n, 1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
               end
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) mdl <= model_reset();
      else       mdl <= step(mdl);
   end

   // Compare every DUT output with the model on each falling edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("stall",       64'(stall),       64'(mdl.busy));
         check("mem_start",   64'(mem_start),   64'(mdl.busy && !is_scalar(mdl.op) && (mdl.age == 0)));
         check("mem_op",      64'(mem_op),      64'(mdl.busy ? mdl.op : 2'b11));
         check("base_addr",   64'(base_addr),   64'(mdl.busy ? mdl.addr : 32'd0));
         check("data_in_esc", 64'(data_in_esc), 64'(mdl.busy ? mdl.desc : 32'd0));
         check("data_in_vec", data_in_vec,      mdl.busy ? mdl.dvec : 64'd0);
         check("wb_valid",    64'(wb_valid),    64'(mdl.wb_valid));
         check("mem_err",     64'(mem_err),     64'(mdl.err));
         if (mdl.wb_valid) begin
            check("wb_en",  64'(wb_en),  64'(mdl.wb_en));
            check("wb_vec", 64'(wb_vec), 64'(mdl.wb_vec));
            check("wb_rd",  64'(wb_rd),  64'(mdl.wb_rd));
            if (mdl.chk_esc) check("wb_data_esc", 64'(wb_data_esc), 64'(mdl.wb_esc));
            if (mdl.chk_vec) check("wb_data_vec", wb_data_vec, mdl.wb_dvec);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      ex_valid    = 1'b0;
      ex_is_mem   = 1'b0;
      ex_mem_op   = 2'b00;
      ex_addr     = '0;
      ex_data_esc = '0;
      ex_data_vec = '0;
      ex_rd       = '0;
      ex_wb_en    = 1'b0;
      ex_wb_vec   = 1'b0;
   endtask

   task automatic drive_ex(input logic is_mem, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] d_esc, input logic [63:0] d_vec,
                           input logic [4:0] rd, input logic wben, input logic wbvec);
      ex_valid    = 1'b1;
      ex_is_mem   = is_mem;
      ex_mem_op   = op;
      ex_addr     = addr;
      ex_data_esc = d_esc;
      ex_data_vec = d_vec;
      ex_rd       = rd;
      ex_wb_en    = wben;
      ex_wb_vec   = wbvec;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_stall"},     64'(stall),       64'd0);
      check({tag, "_mem_start"}, 64'(mem_start),   64'd0);
      check({tag, "_mem_op"},    64'(mem_op),      64'd3);
      check({tag, "_base_addr"}, 64'(base_addr),   64'd0);
      check({tag, "_din_esc"},   64'(data_in_esc), 64'd0);
      check({tag, "_din_vec"},   data_in_vec,      64'd0);
      check({tag, "_wb_valid"},  64'(wb_valid),    64'd0);
      check({tag, "_wb_en"},     64'(wb_en),       64'd0);
      check({tag, "_wb_rd"},     64'(wb_rd),       64'd0);
      check({tag, "_mem_err"},   64'(mem_err),     64'd0);
   endtask

   initial begin
      int wbs;
      int starts;

      drive_idle();
      mem_rdy      = 1'b0;
      data_out_esc = '0;
      data_out_vec = '0;

      // Power-on reset
      #1 reset = 1'b1;
      cyc();
      cyc();
      check_reset_values("por");
      #2 reset = 1'b0;
      chk_on = 1'b1;

      // Non-memory pass-through
      cyc();
      drive_ex(1'b0, 2'b10, 32'h0, 32'h1234, 64'h0, 5'd5, 1'b1, 1'b0);
      cyc();
      drive_idle();
      check("nm_wb_valid", 64'(wb_valid),    64'd1);
      check("nm_wb_rd",    64'(wb_rd),       64'd5);
      check("nm_wb_esc",   64'(wb_data_esc), 64'h1234);
      check("nm_stall",    64'(stall),       64'd0);
      cyc();
      check("nm_wb_drop",  64'(wb_valid),    64'd0);
      check("nm_stall2",   64'(stall),       64'd0);

      // LD_ESC at 0x40, memory returns 0xDEADBEEF
      drive_ex(1'b1, LD_ESC, 32'h40, 32'h0, 64'h0, 5'd9, 1'b1, 1'b0);
      data_out_esc = 32'hDEAD_BEEF;
      cyc();
      drive_idle();
      check("ld_stall1", 64'(stall),     64'd1);
      check("ld_addr1",  64'(base_addr), 64'h40);
      check("ld_op1",    64'(mem_op),    64'(LD_ESC));
      cyc();
      check("ld_stall2", 64'(stall),     64'd1);
      check("ld_addr2",  64'(base_addr), 64'h40);
      check("ld_wbv2",   64'(wb_valid),  64'd0);
      cyc();
      check("ld_wbv3",   64'(wb_valid),    64'd1);
      check("ld_data",   64'(wb_data_esc), 64'hDEAD_BEEF);
      check("ld_wb_en",  64'(wb_en),       64'd1);
      check("ld_stall3", 64'(stall),       64'd0);
      check("ld_addr3",  64'(base_addr),   64'd0);

      // ST_VEC at 0x100, mem_rdy in the 4th VEC_WAIT cycle
      cyc();
      drive_ex(1'b1, ST_VEC, 32'h100, 32'h0, 64'h0011_2233_4455_6677, 5'd2, 1'b1, 1'b1);
      mem_rdy = 1'b0;
      starts  = 0;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         if (i == 1) drive_idle();
         starts += int'(mem_start);
         if (i == 1) check("sv_start1", 64'(mem_start), 64'd1);
         if (i == 2) check("sv_start2", 64'(mem_start), 64'd0);
         if (i <= 5) begin
            check("sv_din_vec", data_in_vec,      64'h0011_2233_4455_6677);
            check("sv_stall",   64'(stall),       64'd1);
            check("sv_wbv",     64'(wb_valid),    64'd0);
         end
         if (i == 5) mem_rdy = 1'b1;
         if (i == 6) begin
            mem_rdy = 1'b0;
            check("sv_wb_valid", 64'(wb_valid), 64'd1);
            check("sv_wb_en",    64'(wb_en),    64'd0);
            check("sv_starts",   64'(starts),   64'd1);
            check("sv_stall6",   64'(stall),    64'd0);
         end
      end

      // LD_VEC completes while the next LD_ESC waits on ex_valid
      wbs = 0;
      drive_ex(1'b1, LD_VEC, 32'h200, 32'h0, 64'h0, 5'd3, 1'b1, 1'b1);
      data_out_vec = 64'hCAFE_F00D_1234_5678;
      cyc();
      wbs += int'(wb_valid);
      drive_ex(1'b1, LD_ESC, 32'h80, 32'h0, 64'h0, 5'd7, 1'b1, 1'b0);
      data_out_esc = 32'h5555_AAAA;
      cyc();
      wbs += int'(wb_valid);
      mem_rdy = 1'b1;
      cyc();
      wbs += int'(wb_valid);
      mem_rdy = 1'b0;
      check("b2b_wbv_vec",  64'(wb_valid),  64'd1);
      check("b2b_data_vec", wb_data_vec,    64'hCAFE_F00D_1234_5678);
      check("b2b_rd_vec",   64'(wb_rd),     64'd3);
      check("b2b_stall0",   64'(stall),     64'd0);
      cyc();
      wbs += int'(wb_valid);
      drive_idle();
      check("b2b_stall1",   64'(stall),     64'd1);
      check("b2b_addr",     64'(base_addr), 64'h80);
      check("b2b_wbv_gap",  64'(wb_valid),  64'd0);
      cyc();
      wbs += int'(wb_valid);
      cyc();
      wbs += int'(wb_valid);
      check("b2b_wbv_esc",  64'(wb_valid),    64'd1);
      check("b2b_rd_esc",   64'(wb_rd),       64'd7);
      check("b2b_data_esc", 64'(wb_data_esc), 64'h5555_AAAA);
      cyc();
      wbs += int'(wb_valid);
      check("b2b_pulses",   64'(wbs),         64'd2);

`ifdef MEM_TIMEOUT_EN
      // Vector op with no mem_rdy: abort after TO VEC_WAIT cycles
      drive_ex(1'b1, LD_VEC, 32'h300, 32'h0, 64'h0, 5'd4, 1'b1, 1'b1);
      data_out_vec = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (i == 1) drive_idle();
         if (i == 9) begin
            check("to_wbv9", 64'(wb_valid), 64'd0);
            check("to_err9", 64'(mem_err),  64'd0);
         end
         if (i == 10) begin
            check("to_wb_valid", 64'(wb_valid),  64'd1);
            check("to_wb_en",    64'(wb_en),     64'd0);
            check("to_wb_vec_d", wb_data_vec,    64'd0);
            check("to_err",      64'(mem_err),   64'd1);
            check("to_stall",    64'(stall),     64'd0);
         end
      end
      drive_ex(1'b0, 2'b00, 32'h0, 32'h77, 64'h88, 5'd11, 1'b1, 1'b0);
      cyc();
      drive_idle();
      check("to_next_wbv",  64'(wb_valid),    64'd1);
      check("to_next_data", 64'(wb_data_esc), 64'h77);
      check("to_sticky",    64'(mem_err),     64'd1);
`endif

      // Reset in the middle of VEC_WAIT
      cyc();
      drive_ex(1'b1, ST_VEC, 32'h400, 32'h0, 64'h1111_2222_3333_4444, 5'd6, 1'b0, 1'b1);
      cyc();
      drive_idle();
      cyc();
      cyc();
      check("rm_stall_pre", 64'(stall), 64'd1);
      #2 reset = 1'b1;
      cyc();
      check_reset_values("rm");
      #2 reset = 1'b0;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         cyc();
         ex_valid     = ($urandom_range(0, 9) < 6);
         ex_is_mem    = ($urandom_range(0, 2) != 0);
         ex_mem_op    = 2'($urandom_range(0, 3));
         ex_addr      = $urandom;
         ex_data_esc  = $urandom;
         ex_data_vec  = {$urandom, $urandom};
         ex_rd        = 5'($urandom_range(0, 31));
         ex_wb_en     = 1'($urandom_range(0, 1));
         ex_wb_vec    = 1'($urandom_range(0, 1));
         mem_rdy      = ($urandom_range(0, 3) == 0);
         data_out_esc = $urandom;
         data_out_vec = {$urandom, $urandom};
      end
      drive_idle();
      mem_rdy = 1'b1;
      repeat (4) cyc();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
